// File: rtl/pipelined_fixed_adder.sv
// pipelined_fixed_adder
//   Pipelined two's-complement add/subtract unit. Operands are split into
//   STAGES segments of SEG = WIDTH/STAGES bits. Stage k adds segment k with
//   the carry registered by stage k-1. Completed low segments, the remaining
//   operand segments and the sub bit travel down the pipe with each entry.
//   valid/ready handshakes on both sides. Each stage loads when it is empty
//   or its contents move on, so bubbles collapse.
//
// Parameters
//   WIDTH  : operand/result width, must be divisible by STAGES
//   STAGES : number of pipeline segments (1 = single registered adder)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   operand pair present           in_ready  operands accepted this cycle
//   sub        0: a+b, 1: a-b                  addend1/addend2  operands a/b
//   out_valid  result present                 out_ready downstream accepts result
//   sum        result (mod 2^WIDTH)           carry_out MSB carry (sub: 1 = no borrow)
//   overflow   signed overflow
//   saturated  overflow && out_valid (only with PIPELINED_FIXED_ADDER_SATURATE_EN)
//
// Build option
//   PIPELINED_FIXED_ADDER_SATURATE_EN: clamp sum to the most-positive or
//   most-negative value on signed overflow, and add the saturated port.
//   When it is undefined, sum wraps modulo 2^WIDTH.

module pipelined_fixed_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] addend1,
  input  logic [WIDTH-1:0] addend2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
`ifdef PIPELINED_FIXED_ADDER_SATURATE_EN
  ,
  output logic             saturated
`endif
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Stage registers (index k = register written by stage k).
  logic [STAGES-1:0]            v_q, v_d;
  logic [STAGES-1:0]            sub_q, sub_d;
  logic [STAGES-1:0]            c_q, c_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
  logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
  logic [STAGES-1:0][WIDTH-1:0] r_q, r_d;
  logic                         ovf_q, ovf_d;

  // Inputs seen by each stage: the ports for stage 0, otherwise the previous register.
  logic [STAGES-1:0]            stg_v, stg_sub, stg_cin;
  logic [STAGES-1:0][WIDTH-1:0] stg_a, stg_b, stg_r;
  logic [STAGES-1:0][SEG-1:0]   b_seg, seg_s;
  logic [STAGES-1:0]            seg_c;
  logic [STAGES-1:0]            load;

  logic [WIDTH-1:0] final_raw;
  logic [WIDTH-1:0] final_sum;
  logic             final_ovf;
  logic             a_msb;
  logic             b_msb;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign stg_v[gi]   = in_valid;
        assign stg_sub[gi] = sub;
        assign stg_a[gi]   = addend1;
        assign stg_b[gi]   = addend2;
        assign stg_r[gi]   = '0;
        // Sub mode: carry-in of 1 completes the two's-complement of b.
        assign stg_cin[gi] = sub;
      end else begin : g_next
        assign stg_v[gi]   = v_q[gi-1];
        assign stg_sub[gi] = sub_q[gi-1];
        assign stg_a[gi]   = a_q[gi-1];
        assign stg_b[gi]   = b_q[gi-1];
        assign stg_r[gi]   = r_q[gi-1];
        assign stg_cin[gi] = c_q[gi-1];
      end

      // Only this stage's segment of b needs inverting.
      assign b_seg[gi] = stg_sub[gi] ? ~stg_b[gi][gi*SEG +: SEG] : stg_b[gi][gi*SEG +: SEG];

      assign {seg_c[gi], seg_s[gi]} = {1'b0, stg_a[gi][gi*SEG +: SEG]}
                                    + {1'b0, b_seg[gi]}
                                    + {{SEG{1'b0}}, stg_cin[gi]};

      // A stage can load if the output is being drained or any register from
      // here to the output is empty: the whole tail then shifts into the hole.
      assign load[gi] = out_ready || !(&v_q[LAST:gi]);
    end
  endgenerate

  // Final-stage result and flags.
  always_comb begin
    final_raw = stg_r[LAST];
    final_raw[LAST*SEG +: SEG] = seg_s[LAST];
  end

  assign a_msb     = stg_a[LAST][WIDTH-1];
  assign b_msb     = b_seg[LAST][SEG-1];
  assign final_ovf = (a_msb == b_msb) && (final_raw[WIDTH-1] != a_msb);

`ifdef PIPELINED_FIXED_ADDER_SATURATE_EN
  // On overflow, the sign of a tells which rail was crossed.
  always_comb begin
    final_sum = final_raw;
    if (final_ovf) begin
      final_sum = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign final_sum = final_raw;
`endif

  // Next state. Data only changes when a valid entry loads, so a bubble
  // never disturbs the held result.
  always_comb begin
    v_d   = v_q;
    sub_d = sub_q;
    c_d   = c_q;
    a_d   = a_q;
    b_d   = b_q;
    r_d   = r_q;
    ovf_d = ovf_q;
    for (int k = 0; k < STAGES; k++) begin
      if (load[k]) begin
        v_d[k] = stg_v[k];
      end
      if (load[k] && stg_v[k]) begin
        sub_d[k] = stg_sub[k];
        a_d[k]   = stg_a[k];
        b_d[k]   = stg_b[k];
        c_d[k]   = seg_c[k];
        r_d[k]   = stg_r[k];
        r_d[k][k*SEG +: SEG] = seg_s[k];
      end
    end
    if (load[LAST] && stg_v[LAST]) begin
      r_d[LAST] = final_sum;
      ovf_d     = final_ovf;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q   <= '0;
      sub_q <= '0;
      c_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      r_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      v_q   <= v_d;
      sub_q <= sub_d;
      c_q   <= c_d;
      a_q   <= a_d;
      b_q   <= b_d;
      r_q   <= r_d;
      ovf_q <= ovf_d;
    end
  end

  // The last stage's operand copies have no consumer and are trimmed.
  logic unused_last_stage;
  assign unused_last_stage = ^{a_q[LAST], b_q[LAST], sub_q[LAST]};

  assign in_ready  = load[0] && !reset;
  assign out_valid = v_q[LAST];
  assign sum       = r_q[LAST];
  assign carry_out = c_q[LAST];
  assign overflow  = ovf_q;
`ifdef PIPELINED_FIXED_ADDER_SATURATE_EN
  assign saturated = ovf_q && v_q[LAST];
`endif

endmodule

// File: tb/tb_pipelined_fixed_adder.sv
// Testbench for pipelined_fixed_adder: a 32-bit/4-stage instance and an
// 8-bit/1-stage instance, checked against an arithmetic reference model.
module tb_pipelined_fixed_adder;
  localparam int W  = 32;
  localparam int S  = 4;
  localparam int W1 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         in_valid, in_ready, sub, out_valid, out_ready, carry_out, overflow;
  logic [W-1:0] addend1, addend2, sum;
  logic          s1_in_valid, s1_in_ready, s1_sub, s1_out_valid, s1_out_ready, s1_carry, s1_ovf;
  logic [W1-1:0] s1_a, s1_b, s1_sum;
`ifdef PIPELINED_FIXED_ADDER_SATURATE_EN
  logic saturated, s1_saturated;
`endif

  pipelined_fixed_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .sub(sub),
    .addend1(addend1), .addend2(addend2), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow)
`ifdef PIPELINED_FIXED_ADDER_SATURATE_EN
    , .saturated(saturated)
`endif
  );

  pipelined_fixed_adder #(.WIDTH(W1), .STAGES(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(s1_in_valid), .in_ready(s1_in_ready), .sub(s1_sub),
    .addend1(s1_a), .addend2(s1_b), .out_valid(s1_out_valid), .out_ready(s1_out_ready),
    .sum(s1_sum), .carry_out(s1_carry), .overflow(s1_ovf)
`ifdef PIPELINED_FIXED_ADDER_SATURATE_EN
    , .saturated(s1_saturated)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { logic [W-1:0] s; logic c; logic o; } exp_t;
  exp_t exp_q[$];

  // Reference: plain integer arithmetic on w-bit values.
  function automatic void ref_op(input int w, input longint unsigned a, input longint unsigned b,
                                 input logic s, output longint unsigned r, output logic co,
                                 output logic ov);
    longint unsigned m;
    longint lim, sa, sb, sr;
    m   = (longint'(1) << w) - 1;
    lim = longint'(1) << (w - 1);
    r   = s ? ((a - b) & m) : ((a + b) & m);
    co  = s ? (a >= b) : (((a + b) >> w) != 0);
    sa  = (a >= lim) ? longint'(a) - 2 * lim : longint'(a);
    sb  = (b >= lim) ? longint'(b) - 2 * lim : longint'(b);
    sr  = s ? sa - sb : sa + sb;
    ov  = (sr >= lim) || (sr < -lim);
`ifdef PIPELINED_FIXED_ADDER_SATURATE_EN
    if (ov) r = (sa < 0) ? 64'(lim) : 64'(lim - 1);
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (sum !== '0) begin n_err++; $display("FAIL reset_sum got %h want 0", sum); end
    n_cmp++; if ({carry_out, overflow} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b want 00", {carry_out, overflow}); end
    n_cmp++; if ({s1_in_ready, s1_out_valid} !== 2'b00) begin n_err++; $display("FAIL reset_s1 got %b want 00", {s1_in_ready, s1_out_valid}); end
    step();
    step();
    reset = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    n_cmp++; if (s1_in_ready !== 1'b1) begin n_err++; $display("FAIL release_s1_in_ready got %b want 1", s1_in_ready); end
    $display("reset: released");
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[4], tb_[4], es[4];
    logic         ts[4], ec[4], eo[4];
    int           lat;
    ta  = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5,         32'h8000_0000};
    tb_ = '{32'h0000_0001, 32'h0000_0001, 32'd7,         32'h0000_0001};
    ts  = '{1'b0,          1'b0,          1'b1,          1'b1};
`ifdef PIPELINED_FIXED_ADDER_SATURATE_EN
    es  = '{32'h0000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h8000_0000};
`else
    es  = '{32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFE, 32'h7FFF_FFFF};
`endif
    ec  = '{1'b1,          1'b0,          1'b0,          1'b1};
    eo  = '{1'b0,          1'b1,          1'b0,          1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; addend1 = ta[i]; addend2 = tb_[i]; sub = ts[i];
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL dir%0d_in_ready got %b want 1", i, in_ready); end
      step();
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 20) begin step(); lat++; end
      n_cmp++; if (lat != S) begin n_err++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, S); end
      n_cmp++; if (sum !== es[i]) begin n_err++; $display("FAIL dir%0d_sum got %h want %h", i, sum, es[i]); end
      n_cmp++; if ({carry_out, overflow} !== {ec[i], eo[i]}) begin n_err++; $display("FAIL dir%0d_flags got %b want %b", i, {carry_out, overflow}, {ec[i], eo[i]}); end
`ifdef PIPELINED_FIXED_ADDER_SATURATE_EN
      n_cmp++; if (saturated !== eo[i]) begin n_err++; $display("FAIL dir%0d_saturated got %b want %b", i, saturated, eo[i]); end
`endif
      $display("directed %0d: %h %s %h -> %h c=%b v=%b lat=%0d", i, ta[i], ts[i] ? "-" : "+", tb_[i], sum, carry_out, overflow, lat);
    end
    step();
  endtask

  task automatic test_random();
    longint unsigned r;
    logic co, ov, pushed, popped, held;
    exp_t e;
    int   n, guard;
    logic [W-1:0] picks[5];
    picks = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h1};
    exp_q.delete();
    held = 1'b0;
    n = 0;
    guard = 0;
    while ((n < 80 || exp_q.size() > 0) && guard < 200) begin
      in_valid  = (n < 80) && ($urandom_range(0, 3) != 0);
      out_ready = (n >= 80) || ($urandom_range(0, 9) < 6);
      sub       = 1'($urandom_range(0, 1));
      addend1   = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 4)] : $urandom;
      addend2   = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 4)] : $urandom;
      #1;
      n_cmp++; if (in_ready !== !(exp_q.size() == S && !out_ready)) begin n_err++; $display("FAIL rnd_in_ready got %b inflight=%0d out_ready=%b", in_ready, exp_q.size(), out_ready); end
      if (held) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rnd_stall_valid got %b want 1", out_valid); end
      end
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL rnd_spurious got valid result %h want none", sum); end
        else if ({sum, carry_out, overflow} !== {exp_q[0].s, exp_q[0].c, exp_q[0].o}) begin
          n_err++; $display("FAIL rnd_result got %h/%b/%b want %h/%b/%b", sum, carry_out, overflow, exp_q[0].s, exp_q[0].c, exp_q[0].o);
        end
      end
      pushed = in_valid && in_ready;
      popped = out_valid && out_ready;
      held   = out_valid && !out_ready;
      if (popped && exp_q.size() > 0) begin
        $display("random out: %h c=%b v=%b", sum, carry_out, overflow);
        void'(exp_q.pop_front());
      end
      if (pushed) begin
        ref_op(W, 64'(addend1), 64'(addend2), sub, r, co, ov);
        e.s = W'(r); e.c = co; e.o = ov;
        exp_q.push_back(e);
        n++;
      end else if (n >= 80) begin
        n = n;
      end
      if (!pushed && !in_valid && n < 80) n = n;
      step();
      guard++;
    end
    in_valid = 1'b0;
    n_cmp++; if (exp_q.size() != 0 || n != 80) begin n_err++; $display("FAIL rnd_drain got pending=%0d accepted=%0d want 0/80", exp_q.size(), n); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] oa[10], ob[10];
    logic         os[10];
    longint unsigned r;
    logic co, ov, fell;
    exp_t e;
    int   idx, t, pops;
    for (int i = 0; i < 10; i++) begin oa[i] = $urandom; ob[i] = $urandom; os[i] = 1'($urandom_range(0, 1)); end
    exp_q.delete();
    idx = 0; t = 0; pops = 0; fell = 1'b0;
    while ((idx < 10 || exp_q.size() > 0) && t < 60) begin
      in_valid  = (idx < 10);
      addend1   = oa[idx % 10]; addend2 = ob[idx % 10]; sub = os[idx % 10];
      out_ready = !(t >= 3 && t <= 8);
      #1;
      if (!in_ready && !fell) begin
        fell = 1'b1;
        n_cmp++; if (idx != S) begin n_err++; $display("FAIL b2b_fill got accepted=%0d at in_ready drop want %0d", idx, S); end
      end
      if (t >= 4 && t <= 8) begin
        n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_stall t=%0d got valid=%b in_ready=%b want 1/0", t, out_valid, in_ready); end
      end
      if (t == 9) begin
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_push_pop got in_ready=%b valid=%b want 1/1", in_ready, out_valid); end
      end
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL b2b_spurious got result %h want none", sum); end
        else if ({sum, carry_out, overflow} !== {exp_q[0].s, exp_q[0].c, exp_q[0].o}) begin
          n_err++; $display("FAIL b2b_result t=%0d got %h/%b/%b want %h/%b/%b", t, sum, carry_out, overflow, exp_q[0].s, exp_q[0].c, exp_q[0].o);
        end
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        $display("b2b out #%0d t=%0d: %h c=%b v=%b", pops, t, sum, carry_out, overflow);
        void'(exp_q.pop_front());
        pops++;
      end
      if (in_valid && in_ready) begin
        ref_op(W, 64'(addend1), 64'(addend2), sub, r, co, ov);
        e.s = W'(r); e.c = co; e.o = ov;
        exp_q.push_back(e);
        idx++;
      end
      step();
      t++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++; if (pops != 10 || idx != 10 || !fell) begin n_err++; $display("FAIL b2b_count got pops=%0d pushes=%0d fell=%b want 10/10/1", pops, idx, fell); end
  endtask

  task automatic test_reset_inflight();
    longint unsigned r;
    logic co, ov;
    int   lat;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; addend1 = $urandom | 32'h1; addend2 = $urandom; sub = 1'b0;
      step();
    end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rst_pre_valid got %b want 1", out_valid); end
    reset = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL rst_async got valid=%b in_ready=%b want 0/0", out_valid, in_ready); end
    n_cmp++; if ({sum, carry_out, overflow} !== '0) begin n_err++; $display("FAIL rst_async_data got %h/%b/%b want 0", sum, carry_out, overflow); end
    step();
    reset = 1'b0; out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got %b want 1", in_ready); end
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_stale cycle %0d got valid=%b want 0", i, out_valid); end
    end
    in_valid = 1'b1; addend1 = 32'h1234_5678; addend2 = 32'h1111_1111; sub = 1'b0;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin step(); lat++; end
    ref_op(W, 64'h1234_5678, 64'h1111_1111, 1'b0, r, co, ov);
    n_cmp++; if (lat != S || sum !== W'(r)) begin n_err++; $display("FAIL rst_first_new got lat=%0d sum=%h want %0d/%h", lat, sum, S, W'(r)); end
    $display("reset in flight: first new result %h after %0d cycles", sum, lat);
    step();
  endtask

  task automatic test_single_stage();
    longint unsigned r;
    logic co, ov;
    logic [W1-1:0] a, b;
    logic s;
    for (int i = 0; i < 8; i++) begin
      a = (i == 0) ? 8'h80 : 8'($urandom_range(0, 255));
      b = (i == 0) ? 8'h80 : 8'($urandom_range(0, 255));
      s = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      ref_op(W1, 64'(a), 64'(b), s, r, co, ov);
      s1_in_valid = 1'b1; s1_a = a; s1_b = b; s1_sub = s;
      #1;
      n_cmp++; if (s1_in_ready !== 1'b1) begin n_err++; $display("FAIL s1_in_ready got %b want 1", s1_in_ready); end
      step();
      s1_in_valid = 1'b0;
      n_cmp++;
      if ({s1_out_valid, s1_sum, s1_carry, s1_ovf} !== {1'b1, W1'(r), co, ov}) begin
        n_err++; $display("FAIL s1_op%0d got v=%b %h/%b/%b want v=1 %h/%b/%b", i, s1_out_valid, s1_sum, s1_carry, s1_ovf, W1'(r), co, ov);
      end
`ifdef PIPELINED_FIXED_ADDER_SATURATE_EN
      n_cmp++; if (s1_saturated !== ov) begin n_err++; $display("FAIL s1_saturated got %b want %b", s1_saturated, ov); end
`endif
      $display("single %0d: %h %s %h -> %h c=%b v=%b", i, a, s ? "-" : "+", b, s1_sum, s1_carry, s1_ovf);
    end
    step();
    n_cmp++; if (s1_out_valid !== 1'b0) begin n_err++; $display("FAIL s1_drain got valid=%b want 0", s1_out_valid); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; sub = 1'b0; out_ready = 1'b1; addend1 = '0; addend2 = '0;
    s1_in_valid = 1'b0; s1_sub = 1'b0; s1_a = '0; s1_b = '0; s1_out_ready = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_inflight();
    test_single_stage();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
